pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
Registered fetch-address unit for the pipelined Y86-64 core. It generalises the SEQ next-PC logic with a parametrised address width and a return-address stack (RAS) of configurable depth. It predicts jXX as taken and predicts ret targets from the RAS. It accepts redirects from the memory stage (jXX mispredict) and the writeback stage (ret mispredict), and supports stall and halt. It sits between the instruction-memory address port and the fetch/decode split logic.

Parameters:
ADDR_W, 64, width of PC and all address inputs
RAS_DEPTH, 8, RAS entries; power of two, at least 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and RAS this cycle (load-use / hazard stall)
f_icode  in  4  icode of the instruction currently at pc
f_valC  in  ADDR_W  constant/destination of the current instruction
f_valP  in  ADDR_W  fall-through address of the current instruction
m_mispredict  in  1  jXX in M resolved not-taken
m_valA  in  ADDR_W  correct fall-through for m_mispredict
w_ret_miss  in  1  ret in W whose fetched target was wrong or absent
w_valM  in  ADDR_W  true return address for w_ret_miss
pc  out  ADDR_W  current fetch address (register)
ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  out  1  sticky: a push overwrote a live entry
ret_wait  out  1  ret fetched with empty RAS; fetch frozen
halted  out  1  halt or invalid icode fetched; fetch frozen

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; RAS pointer=0; ras_count=0; ras_overflow=0; ret_wait=0; halted=0. RAS contents are don't-care. On deassertion, the first update occurs at the next rising edge.
- Per rising edge, priority from highest to lowest:
  1. w_ret_miss: pc<=w_valM. Clear ret_wait and halted. No RAS push/pop for f_icode.
  2. m_mispredict: same as 1, using m_valA.
  3. stall, halted or ret_wait: pc, RAS and flags hold.
  4. Otherwise, predict from f_icode:
     - 0 (halt), or any value >11: pc holds; halted<=1.
     - 7 (jXX, any ifun): pc<=f_valC.
     - 8 (call): pc<=f_valC; push f_valP.
     - 9 (ret), ras_count>0: pc<=top entry; pop.
     - 9 (ret), ras_count==0: pc holds; ret_wait<=1. Cleared only by redirect 1 or 2.
     - 1–6, 10, 11: pc<=f_valP.
- w_ret_miss and m_mispredict in the same cycle: w_ret_miss wins, because the ret is older.
- Redirects override stall, halted and ret_wait.
- RAS is circular, pointer mod RAS_DEPTH.
  - Push when full: overwrite the oldest entry, ras_count stays RAS_DEPTH, ras_overflow<=1. ras_overflow is cleared only by reset.
  - Pop decrements ras_count; it is never issued when ras_count==0.
  - Redirects do not repair the RAS; later misses are corrected by w_ret_miss.
- All outputs are registered. Latency from f_* to new pc is 1 cycle; from redirect to pc is 1 cycle.
- Address arithmetic: none. Values pass through at ADDR_W; no wrap logic is required.

Test Plan:
- Reset mid-run: pc=0x40 with 3 RAS entries, pull rst_n low between edges -> pc=0, ras_count=0, all flags 0 immediately; first edge after release with f_icode=1, f_valP=1 -> pc=1.
- Sequential/jump/call: f_icode=6, f_valP=0x0A -> pc=0x0A. f_icode=7, f_valC=0x1A7 -> pc=0x1A7. f_icode=8, f_valC=0x145, f_valP=0xF3 -> pc=0x145, ras_count=1.
- Ret predict and empty ret: after the call above, f_icode=9 -> pc=0xF3, ras_count=0. Second f_icode=9 -> pc holds, ret_wait=1. w_ret_miss=1, w_valM=0x22B -> pc=0x22B, ret_wait=0.
- RAS overflow (RAS_DEPTH=8): 9 calls with f_valP=1..9 -> ras_count=8, ras_overflow=1. 8 rets -> pc sequence 9,8,...,2. 9th ret -> ret_wait=1.
- Priority: stall=1 with f_icode=8 -> pc and ras_count unchanged. stall=1 with m_mispredict=1, m_valA=0xF3 -> pc=0xF3. m_mispredict and w_ret_miss together with w_valM=0x500 -> pc=0x500.
- Halt: f_icode=0 -> halted=1, pc frozen for 5 cycles regardless of f_*. Then m_mispredict=1, m_valA=0x10 -> pc=0x10, halted=0. Repeat with f_icode=0xC -> same.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Registered fetch-address unit: predicts jXX taken, predicts ret from a circular
// return-address stack, and accepts redirects from M (jXX miss) and W (ret miss).
module pc_fetch_ctrl #(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic [3:0]                   f_icode,
  input  logic [ADDR_W-1:0]            f_valC,
  input  logic [ADDR_W-1:0]            f_valP,
  input  logic                         m_mispredict,
  input  logic [ADDR_W-1:0]            m_valA,
  input  logic                         w_ret_miss,
  input  logic [ADDR_W-1:0]            w_valM,
  output logic [ADDR_W-1:0]            pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ret_wait,
  output logic                         halted
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_pc;
  logic              r_overflow;
  logic              r_ret_wait;
  logic              r_halted;

  logic              w_run;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_bad_op;
  logic [ADDR_W-1:0] w_top;

  always_comb begin
    w_run    = !w_ret_miss && !m_mispredict && !stall && !r_halted && !r_ret_wait;
    w_full   = (r_count == FULL_CNT);
    w_bad_op = (f_icode == 4'd0) || (f_icode > 4'd11);
    w_push   = w_run && (f_icode == 4'd8);
    w_pop    = w_run && (f_icode == 4'd9) && (r_count != '0);
    w_top    = r_ras[r_ptr - PTR_W'(1)];
  end

  // r_ptr always names the next free slot, so when full it also names the oldest entry
  always_ff @(posedge clk) begin
    if (w_push) r_ras[r_ptr] <= f_valP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_ptr      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_ret_wait <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (w_ret_miss) begin
        r_pc       <= w_valM;
        r_ret_wait <= 1'b0;
        r_halted   <= 1'b0;
      end else if (m_mispredict) begin
        r_pc       <= m_valA;
        r_ret_wait <= 1'b0;
        r_halted   <= 1'b0;
      end else if (w_run) begin
        if (w_bad_op) begin
          r_halted <= 1'b1;
        end else begin
          case (f_icode)
            4'd7:    r_pc <= f_valC;
            4'd8:    r_pc <= f_valC;
            4'd9: begin
              if (r_count != '0) r_pc <= w_top;
              else               r_ret_wait <= 1'b1;
            end
            default: r_pc <= f_valP;
          endcase
        end
      end

      // Stack bookkeeping; a full push overwrites the oldest entry
      if (w_push) begin
        r_ptr <= r_ptr + PTR_W'(1);
        if (w_full) r_overflow <= 1'b1;
        else        r_count    <= r_count + (PTR_W+1)'(1);
      end else if (w_pop) begin
        r_ptr   <= r_ptr - PTR_W'(1);
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

  assign pc           = r_pc;
  assign ras_count    = r_count;
  assign ras_overflow = r_overflow;
  assign ret_wait     = r_ret_wait;
  assign halted       = r_halted;

endmodule
